// File: rtl/bouncing_square_pkg.sv
// Shared display definitions: video mode timing, border default, RGB colours
// and the sync-polarity helper used by the pixel-pipeline stages.
package bouncing_square_pkg;

  // 640x480 @ 60 Hz
  localparam int unsigned H_640      = 640;
  localparam int unsigned HFP_640    = 16;
  localparam int unsigned HSW_640    = 96;
  localparam int unsigned HBP_640    = 48;
  localparam int unsigned V_480      = 480;
  localparam int unsigned VFP_480    = 10;
  localparam int unsigned VSW_480    = 2;
  localparam int unsigned VBP_480    = 33;

  // 1280x1024 @ 60 Hz
  localparam int unsigned H_1280     = 1280;
  localparam int unsigned HFP_1280   = 48;
  localparam int unsigned HSW_1280   = 112;
  localparam int unsigned HBP_1280   = 248;
  localparam int unsigned V_1024     = 1024;
  localparam int unsigned VFP_1024   = 1;
  localparam int unsigned VSW_1024   = 3;
  localparam int unsigned VBP_1024   = 38;

  localparam int unsigned BORDER_DEFAULT = 21;

  localparam logic [2:0] RGB_BLACK   = 3'b000;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_WHITE   = 3'b111;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_e;

  // Pin level of a sync signal for a given logical state and polarity.
  function automatic logic sync_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/bouncing_square_if.sv
// Pixel bus between the timing/border chain and the square overlay stage:
// timing and background colour in, composited colour and delayed syncs out.
interface bouncing_square_if;
  logic [31:0] x;
  logic [31:0] y;
  logic        enable;
  logic        hsync_in;
  logic        vsync_in;
  logic        bg_r;
  logic        bg_g;
  logic        bg_b;
  logic        r;
  logic        g;
  logic        b;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;

  modport master (
    output x, y, enable, hsync_in, vsync_in, bg_r, bg_g, bg_b,
    input  r, g, b, hsync_out, vsync_out, de_out
  );

  modport slave (
    input  x, y, enable, hsync_in, vsync_in, bg_r, bg_g, bg_b,
    output r, g, b, hsync_out, vsync_out, de_out
  );
endinterface

// File: rtl/bouncing_square_bounce_axis.sv
// One axis of the square's motion: position and direction registers, stepping
// once per accepted frame tick and reflecting off the LO/HI limits.
module bounce_axis
  import bouncing_square_pkg::*;
#(
  parameter int unsigned LO   = 21,
  parameter int unsigned HI   = 587,
  parameter int unsigned STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        run,
  output logic [31:0] pos,
  output logic        flipped
);

  localparam logic [31:0] LO_C   = 32'(LO);
  localparam logic [31:0] HI_C   = 32'(HI);
  localparam logic [31:0] STEP_C = 32'(STEP);

  logic [31:0] pos_q;
  logic [31:0] pos_d;
  dir_e        dir_q;
  dir_e        dir_d;
  logic        flip_s;

  // Next position/direction; landing exactly on a limit counts as a bounce.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    flip_s = 1'b0;
    if (tick && run) begin
      case (dir_q)
        DIR_POS: begin
          if (pos_q + STEP_C >= HI_C) begin
            pos_d  = HI_C;
            dir_d  = DIR_NEG;
            flip_s = 1'b1;
          end else begin
            pos_d  = pos_q + STEP_C;
          end
        end
        DIR_NEG: begin
          if (pos_q <= LO_C + STEP_C) begin
            pos_d  = LO_C;
            dir_d  = DIR_POS;
            flip_s = 1'b1;
          end else begin
            pos_d  = pos_q - STEP_C;
          end
        end
        default: begin
          pos_d = LO_C;
          dir_d = DIR_POS;
        end
      endcase
    end else begin
      pos_d = pos_q;
    end
  end

  // Position and direction state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= LO_C;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos     = pos_q;
  assign flipped = flip_s;

endmodule

// File: rtl/bouncing_square.sv
// Overlays a square bouncing inside the border field onto the background
// colour, delaying syncs and display enable so all outputs leave aligned.
module bouncing_square
  import bouncing_square_pkg::*;
#(
  parameter int unsigned H             = H_640,
  parameter int unsigned V             = V_480,
  parameter int unsigned BORDER        = BORDER_DEFAULT,
  parameter int unsigned SIZE          = 32,
  parameter int unsigned STEP          = 2,
  parameter logic [2:0]  SQ_RGB        = RGB_YELLOW,
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter bit          HS_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  bouncing_square_if.slave    pix,
  input  logic                run,
  output logic [31:0]         sq_x,
  output logic [31:0]         sq_y,
  output logic [7:0]          bounces
);

  if ((H < 2 * BORDER + SIZE + STEP) || (V < 2 * BORDER + SIZE + STEP)) begin : g_geom_check
    $error("bouncing_square: SIZE+STEP does not fit inside the border field");
  end

  localparam int unsigned HI_X   = H - BORDER - SIZE;
  localparam int unsigned HI_Y   = V - BORDER - SIZE;
  localparam logic [31:0] SIZE_C = 32'(SIZE);
  localparam logic        VS_ON  = sync_level(1'b1, VS_ACTIVE_LOW);
  localparam logic        VS_OFF = sync_level(1'b0, VS_ACTIVE_LOW);
  localparam logic        HS_OFF = sync_level(1'b0, HS_ACTIVE_LOW);

  logic [31:0] sq_x_s;
  logic [31:0] sq_y_s;
  logic        flip_x_s;
  logic        flip_y_s;
  logic        tick_s;

  logic        hit_q, hit_d;
  logic        de_d1_q;
  logic        hs_d1_q;
  logic        vs_d1_q;
  logic        vs_hist_q;
  logic        armed_q, armed_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        de_q;
  logic        hs_q;
  logic        vs_q;
  logic [7:0]  bounces_q, bounces_d;

  // armed_q blocks a tick until a genuine inactive vsync has been seen after
  // reset, so vsync already active at reset release cannot move the square.
  assign tick_s  = armed_q && (vs_d1_q == VS_ON) && (vs_hist_q == VS_OFF);

  bounce_axis #(
    .LO   (BORDER),
    .HI   (HI_X),
    .STEP (STEP)
  ) u_axis_x (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick_s),
    .run     (run),
    .pos     (sq_x_s),
    .flipped (flip_x_s)
  );

  bounce_axis #(
    .LO   (BORDER),
    .HI   (HI_Y),
    .STEP (STEP)
  ) u_axis_y (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick_s),
    .run     (run),
    .pos     (sq_y_s),
    .flipped (flip_y_s)
  );

  // Stage-1 hit test against the current corner, plus tick arming.
  always_comb begin
    hit_d   = 1'b0;
    armed_d = armed_q;
    if (pix.enable &&
        (pix.x >= sq_x_s) && (pix.x < sq_x_s + SIZE_C) &&
        (pix.y >= sq_y_s) && (pix.y < sq_y_s + SIZE_C)) begin
      hit_d = 1'b1;
    end else begin
      hit_d = 1'b0;
    end
    if (pix.vsync_in == VS_OFF) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Stage-2 colour select and bounce counting (one count per tick at most).
  always_comb begin
    rgb_d     = RGB_BLACK;
    bounces_d = bounces_q;
    if (de_d1_q) begin
      if (hit_q) begin
        rgb_d = SQ_RGB;
      end else begin
        rgb_d = {pix.bg_r, pix.bg_g, pix.bg_b};
      end
    end else begin
      rgb_d = RGB_BLACK;
    end
    if (flip_x_s || flip_y_s) begin
      bounces_d = bounces_q + 8'd1;
    end else begin
      bounces_d = bounces_q;
    end
  end

  // Stage-1 pipeline and vsync history.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q     <= 1'b0;
      de_d1_q   <= 1'b0;
      hs_d1_q   <= HS_OFF;
      vs_d1_q   <= VS_OFF;
      vs_hist_q <= VS_OFF;
      armed_q   <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      de_d1_q   <= pix.enable;
      hs_d1_q   <= pix.hsync_in;
      vs_d1_q   <= pix.vsync_in;
      vs_hist_q <= vs_d1_q;
      armed_q   <= armed_d;
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q     <= RGB_BLACK;
      de_q      <= 1'b0;
      hs_q      <= HS_OFF;
      vs_q      <= VS_OFF;
      bounces_q <= 8'd0;
    end else begin
      rgb_q     <= rgb_d;
      de_q      <= de_d1_q;
      hs_q      <= hs_d1_q;
      vs_q      <= vs_d1_q;
      bounces_q <= bounces_d;
    end
  end

  assign pix.r         = rgb_q[2];
  assign pix.g         = rgb_q[1];
  assign pix.b         = rgb_q[0];
  assign pix.de_out    = de_q;
  assign pix.hsync_out = hs_q;
  assign pix.vsync_out = vs_q;
  assign sq_x          = sq_x_s;
  assign sq_y          = sq_y_s;
  assign bounces       = bounces_q;

endmodule

// File: tb/tb_bouncing_square.sv
// Bench for bouncing_square: a frame-level reference model checked every
// cycle, a table of compositing vectors and directed corner sequences.
module tb_bouncing_square;

  localparam int B    = 21;
  localparam int S    = 32;
  localparam int ST   = 2;
  localparam int HI_X = 640 - B - S;
  localparam int HI_Y = 480 - B - S;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        run_c;
  logic [31:0] sq_x, sq_y, cx, cy;
  logic [7:0]  bounces, cb;

  always #5 clk = ~clk;

  bouncing_square_if pix ();
  bouncing_square_if pixc ();

  bouncing_square dut (
    .clk(clk), .rst(rst), .pix(pix.slave), .run(run),
    .sq_x(sq_x), .sq_y(sq_y), .bounces(bounces)
  );

  bouncing_square #(.H(100), .V(100), .BORDER(10), .SIZE(10), .STEP(5)) dut_c (
    .clk(clk), .rst(rst), .pix(pixc.slave), .run(run_c),
    .sq_x(cx), .sq_y(cy), .bounces(cb)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int         m_x, m_y;
  bit         m_px, m_py;
  logic [7:0] m_b;
  bit         s1_hit, s1_de, s1_hs, s1_vs;
  logic [2:0] o_rgb;
  bit         o_de, o_hs, o_vs;
  bit         tick_pend, prev_valid, prev_act;
  bit         rnd_pix;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        en;
    logic [2:0]  bg;
    logic [2:0]  rgb;
    logic        de;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic axis_move(inout int p, inout bit up, input int hi, output bit flip);
    flip = 1'b0;
    if (up) begin
      if (p + ST >= hi) begin p = hi; up = 1'b0; flip = 1'b1; end
      else p = p + ST;
    end else begin
      if (p <= B + ST) begin p = B; up = 1'b1; flip = 1'b1; end
      else p = p - ST;
    end
  endtask

  // What the block must have done at the coming clock edge, given current inputs.
  task automatic model_edge();
    bit fx, fy, act;
    if (rst) begin
      m_x = B; m_y = B; m_px = 1'b1; m_py = 1'b1; m_b = 8'd0;
      s1_hit = 1'b0; s1_de = 1'b0; s1_hs = 1'b1; s1_vs = 1'b1;
      o_rgb = 3'b000; o_de = 1'b0; o_hs = 1'b1; o_vs = 1'b1;
      tick_pend = 1'b0; prev_valid = 1'b0; prev_act = 1'b0;
    end else begin
      o_rgb = s1_de ? (s1_hit ? 3'b110 : {pix.bg_r, pix.bg_g, pix.bg_b}) : 3'b000;
      o_de = s1_de; o_hs = s1_hs; o_vs = s1_vs;
      s1_hit = pix.enable &&
               (longint'(pix.x) >= m_x) && (longint'(pix.x) < m_x + S) &&
               (longint'(pix.y) >= m_y) && (longint'(pix.y) < m_y + S);
      s1_de = pix.enable; s1_hs = pix.hsync_in; s1_vs = pix.vsync_in;
      if (tick_pend && run) begin
        axis_move(m_x, m_px, HI_X, fx);
        axis_move(m_y, m_py, HI_Y, fy);
        if (fx || fy) m_b = m_b + 8'd1;
      end
      act = (pix.vsync_in == 1'b0);
      tick_pend = act && prev_valid && !prev_act;
      prev_valid = 1'b1;
      prev_act = act;
    end
  endtask

  task automatic cyc();
    if (rnd_pix) begin
      pix.x = $urandom_range(0, 700);
      pix.y = $urandom_range(0, 520);
      pix.enable = 1'($urandom_range(0, 1));
      pix.hsync_in = 1'($urandom_range(0, 1));
      {pix.bg_r, pix.bg_g, pix.bg_b} = 3'($urandom_range(0, 7));
    end
    model_edge();
    @(posedge clk);
    #1;
    check("pix_out", 64'({pix.r, pix.g, pix.b, pix.de_out, pix.hsync_out, pix.vsync_out}),
          64'({o_rgb, o_de, o_hs, o_vs}));
    check("sq_pos", {sq_x, sq_y}, {m_x[31:0], m_y[31:0]});
    check("bounces", 64'(bounces), 64'(m_b));
  endtask

  task automatic ftick();
    pix.vsync_in = 1'b1; cyc();
    pix.vsync_in = 1'b0; cyc(); cyc();
    pix.vsync_in = 1'b1; cyc();
  endtask

  task automatic ftick_fast();
    pix.vsync_in = 1'b0; cyc();
    pix.vsync_in = 1'b1; cyc();
  endtask

  task automatic ctick();
    pixc.vsync_in = 1'b0; cyc();
    pixc.vsync_in = 1'b1; cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'd21,  32'd21,  1'b1, 3'b010, 3'b110, 1'b1};
    tbl[1] = '{32'd53,  32'd21,  1'b1, 3'b010, 3'b010, 1'b1};
    tbl[2] = '{32'd52,  32'd52,  1'b1, 3'b010, 3'b110, 1'b1};
    tbl[3] = '{32'd20,  32'd21,  1'b1, 3'b010, 3'b010, 1'b1};
    tbl[4] = '{32'd21,  32'd53,  1'b1, 3'b101, 3'b101, 1'b1};
    tbl[5] = '{32'd30,  32'd30,  1'b0, 3'b010, 3'b000, 1'b0};
    tbl[6] = '{32'd100, 32'd100, 1'b0, 3'b111, 3'b000, 1'b0};

    rst = 1'b1; run = 1'b1; run_c = 1'b0; rnd_pix = 1'b0;
    pix.x = 32'd0; pix.y = 32'd0; pix.enable = 1'b0; pix.hsync_in = 1'b1;
    pix.vsync_in = 1'b0; {pix.bg_r, pix.bg_g, pix.bg_b} = 3'b000;
    pixc.x = 32'd0; pixc.y = 32'd0; pixc.enable = 1'b0; pixc.hsync_in = 1'b1;
    pixc.vsync_in = 1'b1; {pixc.bg_r, pixc.bg_g, pixc.bg_b} = 3'b000;

    // reset with vsync active, released while still active
    repeat (3) cyc();
    check("rst_sq", {sq_x, sq_y}, {32'd21, 32'd21});
    check("rst_bounces", 64'(bounces), 64'd0);
    check("rst_rgb_de", 64'({pix.r, pix.g, pix.b, pix.de_out}), 64'd0);
    rst = 1'b0;
    repeat (4) cyc();
    check("no_tick_at_release", {sq_x, sq_y}, {32'd21, 32'd21});
    ftick();
    check("tick1", {sq_x, sq_y}, {32'd23, 32'd23});

    // long motion run through both first bounces
    rnd_pix = 1'b1;
    for (int t = 2; t <= 284; t++) begin
      ftick();
      if (t == 203) begin
        check("t203_y", 64'(sq_y), 64'd427);
        check("t203_b", 64'(bounces), 64'd1);
      end
      if (t == 204) check("t204_y", 64'(sq_y), 64'd425);
      if (t == 283) begin
        check("t283_x", 64'(sq_x), 64'd587);
        check("t283_b", 64'(bounces), 64'd2);
      end
      if (t == 284) check("t284_x", 64'(sq_x), 64'd585);
    end

    // compositing table, square at (21,21)
    rnd_pix = 1'b0;
    pix.vsync_in = 1'b1;
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pix.x = tbl[i].x; pix.y = tbl[i].y; pix.enable = tbl[i].en;
      {pix.bg_r, pix.bg_g, pix.bg_b} = ~tbl[i].bg;
      cyc();
      pix.x = 32'd0; pix.y = 32'd0; pix.enable = 1'b0;
      {pix.bg_r, pix.bg_g, pix.bg_b} = tbl[i].bg;
      cyc();
      check($sformatf("tbl%0d_rgb", i), 64'({pix.r, pix.g, pix.b}), 64'(tbl[i].rgb));
      check($sformatf("tbl%0d_de", i), 64'(pix.de_out), 64'(tbl[i].de));
    end

    // freeze, then hsync alignment
    repeat (3) ftick();
    run = 1'b0;
    repeat (5) ftick();
    check("freeze_sq", {sq_x, sq_y}, {32'd27, 32'd27});
    check("freeze_b", 64'(bounces), 64'd0);
    run = 1'b1;
    pix.hsync_in = 1'b1; cyc(); cyc();
    pix.hsync_in = 1'b0; cyc();
    pix.hsync_in = 1'b1;
    check("hs_pulse_d1", 64'(pix.hsync_out), 64'd1);
    cyc();
    check("hs_pulse_d2", 64'(pix.hsync_out), 64'd0);
    cyc();
    check("hs_pulse_d3", 64'(pix.hsync_out), 64'd1);

    // random traffic against the model
    rnd_pix = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 7) != 0);
      pix.vsync_in = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; run = 1'b1;

    // drive to sq_x=101 with Y moving down, then reset with a tick pending
    pix.vsync_in = 1'b1;
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    for (int k = 0; k < 2000 && !(m_x == 101 && !m_py); k++) ftick_fast();
    check("pre_rst_sq", {sq_x, sq_y}, {32'd101, 32'd273});
    rst = 1'b1; cyc(); rst = 1'b0;
    check("mid_rst_sq", {sq_x, sq_y}, {32'd21, 32'd21});
    check("mid_rst_b", 64'(bounces), 64'd0);
    check("mid_rst_out", 64'({pix.r, pix.g, pix.b, pix.de_out, pix.hsync_out, pix.vsync_out}), 64'b000011);
    pix.vsync_in = 1'b1; cyc();
    ftick();
    check("post_rst_dir", {sq_x, sq_y}, {32'd23, 32'd23});

    // small geometry: corner bounce and counter wrap
    run_c = 1'b1;
    for (int n = 1; n <= 14 * 256; n++) begin
      ctick();
      if (n == 13) check("c13", {cx, cy}, {32'd75, 32'd75});
      if (n == 14) begin
        check("c14_pos", {cx, cy}, {32'd80, 32'd80});
        check("c14_b", 64'(cb), 64'd1);
      end
      if (n == 28) check("c28_b", 64'(cb), 64'd2);
      if (n == 14 * 255) begin
        check("c255_b", 64'(cb), 64'd255);
        check("c255_pos", {cx, cy}, {32'd80, 32'd80});
      end
      if (n == 14 * 256) begin
        check("c256_b", 64'(cb), 64'd0);
        check("c256_pos", {cx, cy}, {32'd10, 32'd10});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
